// File: rtl/ms_riscv32_mp_pkg.sv
// Shared definitions for the ms_riscv32_mp instruction fetch path:
// queue entry layout, bus transfer encodings and reset defaults.
package ms_riscv32_mp_pkg;

    // Fetch address used when the core leaves reset, unless overridden.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction word placed in entries that carry no valid bus data
    // (bus errors and misaligned redirect targets).
    localparam logic [31:0] INSTR_ZERO = 32'h0000_0000;

    // AHB-Lite HTRANS encodings used by the instruction port.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // One prefetch queue entry as seen by decode.
    typedef struct packed {
        logic [31:0] instr;  // fetched instruction word
        logic [31:0] pc;     // address the word was fetched from
        logic        err;    // bus returned HRESP error for this fetch
        logic        misal;  // redirect target was not word aligned
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    // Build an entry from its fields.
    function automatic fetch_entry_t make_entry(
        input logic [31:0] instr,
        input logic [31:0] pc,
        input logic        err,
        input logic        misal
    );
        fetch_entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.err   = err;
        e.misal = misal;
        return e;
    endfunction

endpackage

// File: rtl/ms_riscv32_mp_sync_fifo.sv
// Synchronous FIFO with single-cycle clear and occupancy count.
// The head word reads as zero while the FIFO is empty so downstream
// outputs stay at a known value without resetting the storage array.
module ms_riscv32_mp_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             empty;
    logic             do_pop;

    // Pop is ignored on an empty FIFO; head reads zero when empty.
    always_comb begin
        empty    = (cnt == '0);
        do_pop   = pop && !empty;
        pop_data = empty ? '0 : mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; clear wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign count = cnt;

endmodule

// File: rtl/ms_riscv32_mp_fetch_queue.sv
// Instruction prefetch queue between the AHB-Lite instruction port and
// decode. Issues word fetches ahead of decode, tracks the one outstanding
// data phase, discards data that a redirect made stale, and tags entries
// with bus-error and misaligned-target flags.
//
// Handshake: an entry moves to decode on a rising edge where valid_out and
// deq_ready_in are both 1; valid_out and the head fields do not depend on
// deq_ready_in, and the head stays stable until it is taken or flushed.
module ms_riscv32_mp_fetch_queue
    import ms_riscv32_mp_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   ms_riscv32_mp_clk_in,
    input  logic                   ms_riscv32_mp_rst_in,
    input  logic                   redirect_valid_in,
    input  logic [31:0]            redirect_pc_in,
    output logic                   instr_req_out,
    output logic [31:0]            imaddr_out,
    input  logic                   instr_hready_in,
    input  logic                   instr_hresp_in,
    input  logic [31:0]            instr_in,
    input  logic                   deq_ready_in,
    output logic                   valid_out,
    output logic [31:0]            instr_out,
    output logic [31:0]            pc_out,
    output logic                   fetch_err_out,
    output logic                   misaligned_instr_out,
    output logic [$clog2(DEPTH):0] count_out
);

    localparam int             CW          = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_LIMIT = (CW + 1)'(DEPTH);

    // Fetch control state.
    logic [31:0]  fetch_pc;
    logic         dphase_pending;
    logic [31:0]  dphase_pc;
    logic         dphase_discard;
    logic         halted;
    logic         misal_pending;

    // Datapath / handshake signals.
    logic [CW-1:0] count;
    logic [CW:0]   inflight;
    logic          issue;
    logic [1:0]    htrans;
    logic          addr_accept;
    logic          data_done;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Issue decision: keep room in the queue for every fetch already on
    // the bus, stay quiet while halted, during reset and on a redirect.
    // Reset gates the request so the port shows IDLE while held in reset.
    always_comb begin
        inflight    = {1'b0, count} + {{CW{1'b0}}, dphase_pending};
        issue       = ms_riscv32_mp_rst_in && !halted && !misal_pending &&
                      !redirect_valid_in && (inflight < DEPTH_LIMIT);
        htrans      = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
        addr_accept = (htrans == HTRANS_NONSEQ) && instr_hready_in;
        data_done   = dphase_pending && instr_hready_in;
    end

    // Queue write selection: misaligned marker entry or completed bus data.
    // Nothing is written in a redirect cycle because the queue is cleared.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (!redirect_valid_in) begin
            if (misal_pending) begin
                push       = 1'b1;
                push_entry = make_entry(INSTR_ZERO, fetch_pc, 1'b0, 1'b1);
            end else if (data_done && !dphase_discard) begin
                push       = 1'b1;
                push_entry = make_entry(instr_hresp_in ? INSTR_ZERO : instr_in,
                                        dphase_pc, instr_hresp_in, 1'b0);
            end
        end
    end

    // Dequeue on the decode handshake.
    always_comb begin
        pop = valid_out && deq_ready_in;
    end

    // Fetch PC, data-phase tracking and halt control; redirect has priority.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            fetch_pc       <= RESET_PC;
            dphase_pending <= 1'b0;
            dphase_pc      <= '0;
            dphase_discard <= 1'b0;
            halted         <= 1'b0;
            misal_pending  <= 1'b0;
        end else if (redirect_valid_in) begin
            fetch_pc      <= redirect_pc_in;
            halted        <= 1'b0;
            misal_pending <= (redirect_pc_in[1:0] != 2'b00);
            // A data phase still waiting must run to completion on the bus,
            // but its word belongs to the old stream.
            if (dphase_pending && !instr_hready_in) begin
                dphase_discard <= 1'b1;
            end else begin
                dphase_pending <= 1'b0;
                dphase_discard <= 1'b0;
            end
        end else begin
            if (addr_accept) begin
                fetch_pc       <= fetch_pc + 32'd4;
                dphase_pending <= 1'b1;
                dphase_pc      <= fetch_pc;
                dphase_discard <= 1'b0;
            end else if (data_done) begin
                dphase_pending <= 1'b0;
                dphase_discard <= 1'b0;
            end
            if (data_done && !dphase_discard && instr_hresp_in) begin
                halted <= 1'b1;
            end
            if (misal_pending) begin
                misal_pending <= 1'b0;
                halted        <= 1'b1;
            end
        end
    end

    ms_riscv32_mp_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fifo (
        .clk       (ms_riscv32_mp_clk_in),
        .rst_n     (ms_riscv32_mp_rst_in),
        .clear     (redirect_valid_in),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (count)
    );

    // Output mapping; head fields read zero when the queue is empty.
    always_comb begin
        instr_req_out        = (htrans == HTRANS_NONSEQ);
        imaddr_out           = fetch_pc;
        valid_out            = (count != '0);
        instr_out            = head.instr;
        pc_out               = head.pc;
        fetch_err_out        = head.err;
        misaligned_instr_out = head.misal;
        count_out            = count;
    end

endmodule

// File: tb/tb_ms_riscv32_mp_fetch_queue.sv
// Bench for the prefetch queue: a small AHB slave model answers fetches,
// directed scenarios push expected entries, and a monitor compares each
// entry decode accepts against the expected queue.
module tb_ms_riscv32_mp_fetch_queue;

    localparam int W = 66;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_req;
    logic [31:0] imaddr;
    logic        hready;
    logic        hresp;
    logic [31:0] instr_bus;
    logic        deq_ready;
    logic        valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        fetch_err;
    logic        misal;
    logic [2:0]  count;

    logic        bus_stall;
    logic [31:0] err_addr;
    logic        tb_pend;
    logic [31:0] tb_addr;

    logic [W-1:0] exp_q[$];
    int n_tests;
    int n_fail;

    ms_riscv32_mp_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .redirect_valid_in    (redirect_valid),
        .redirect_pc_in       (redirect_pc),
        .instr_req_out        (instr_req),
        .imaddr_out           (imaddr),
        .instr_hready_in      (hready),
        .instr_hresp_in       (hresp),
        .instr_in             (instr_bus),
        .deq_ready_in         (deq_ready),
        .valid_out            (valid),
        .instr_out            (instr_out),
        .pc_out               (pc_out),
        .fetch_err_out        (fetch_err),
        .misaligned_instr_out (misal),
        .count_out            (count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic void push_exp(input logic [31:0] instr, input logic [31:0] pc,
                                     input logic err, input logic mis);
        exp_q.push_back({instr, pc, err, mis});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Wait (bounded) for the head entry to appear.
    task automatic wait_valid();
        int i;
        i = 0;
        while (!valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("wait_valid", 32'(valid), 32'd1);
    endtask

    // Let decode take exactly n entries from a contiguous stream.
    task automatic drain(input int n);
        deq_ready = 1'b1;
        repeat (n) @(negedge clk);
        deq_ready = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
    endtask

    // ---------------- AHB slave model ----------------
    initial begin : bus_model
        logic        do_acc;
        logic        do_done;
        logic [31:0] acc_addr;
        hready    = 1'b1;
        hresp     = 1'b0;
        instr_bus = 32'h0;
        tb_pend   = 1'b0;
        tb_addr   = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            hready    = !bus_stall;
            hresp     = tb_pend && (tb_addr == err_addr);
            instr_bus = tb_pend ? data_of(tb_addr) : 32'h0;
            do_done   = tb_pend && hready;
            do_acc    = instr_req && hready;
            acc_addr  = imaddr;
            @(posedge clk);
            if (!rst_n) begin
                tb_pend = 1'b0;
            end else begin
                if (do_done) tb_pend = 1'b0;
                if (do_acc) begin
                    tb_pend = 1'b1;
                    tb_addr = acc_addr;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && valid && deq_ready && !redirect_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL deq_unexpected: got pc %h instr %h, expected no entry", pc_out, instr_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({instr_out, pc_out, fetch_err, misal} !== e) begin
                        n_fail++;
                        $display("FAIL deq_entry: got instr=%h pc=%h err=%b misal=%b, expected instr=%h pc=%h err=%b misal=%b",
                                 instr_out, pc_out, fetch_err, misal, e[65:34], e[33:2], e[1], e[0]);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stimulus
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        deq_ready      = 1'b0;
        bus_stall      = 1'b0;
        err_addr       = 32'hFFFF_FFFF;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_req", 32'(instr_req), 32'd0);
        check("rst_addr", imaddr, 32'h0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_misal", 32'(misal), 32'd0);
        check("rst_count", 32'(count), 32'd0);

        // Zero-wait streaming from RESET_PC
        rst_n = 1'b1;
        #1;
        check("start_req", 32'(instr_req), 32'd1);
        check("start_addr", imaddr, 32'h0);
        @(negedge clk);
        check("c1_valid", 32'(valid), 32'd0);
        check("c1_addr", imaddr, 32'h4);
        @(negedge clk);
        check("c2_valid", 32'(valid), 32'd1);
        check("c2_pc", pc_out, 32'h0);
        for (int i = 0; i < 5; i++) push_exp(data_of(32'(i * 4)), 32'(i * 4), 1'b0, 1'b0);
        drain(5);

        // Decode stalled: queue fills to DEPTH, requests stop
        repeat (6) @(negedge clk);
        check("full_count", 32'(count), 32'd4);
        check("full_req", 32'(instr_req), 32'd0);
        check("full_addr", imaddr, 32'h24);
        for (int i = 0; i < 6; i++) push_exp(data_of(32'h14 + 32'(i * 4)), 32'h14 + 32'(i * 4), 1'b0, 1'b0);
        drain(6);
        repeat (8) @(negedge clk);

        // Redirect during a wait-stated data phase
        redirect_to(32'h40);
        check("redir_valid_low", 32'(valid), 32'd0);
        check("redir_req", 32'(instr_req), 32'd1);
        check("redir_addr", imaddr, 32'h40);
        @(negedge clk);
        bus_stall = 1'b1;
        @(negedge clk);
        redirect_to(32'h100);
        check("stall_req", 32'(instr_req), 32'd1);
        check("stall_addr", imaddr, 32'h100);
        @(negedge clk);
        bus_stall = 1'b0;
        check("discard_valid", 32'(valid), 32'd0);
        check("discard_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) push_exp(data_of(32'h100 + 32'(i * 4)), 32'h100 + 32'(i * 4), 1'b0, 1'b0);
        wait_valid();
        drain(3);
        repeat (8) @(negedge clk);

        // Bus error on 0x8; the fetch of 0xC overlaps the error data phase
        err_addr = 32'h8;
        redirect_to(32'h0);
        repeat (10) @(negedge clk);
        check("err_count", 32'(count), 32'd4);
        check("err_addr", imaddr, 32'h10);
        push_exp(data_of(32'h0), 32'h0, 1'b0, 1'b0);
        push_exp(data_of(32'h4), 32'h4, 1'b0, 1'b0);
        push_exp(32'h0, 32'h8, 1'b1, 1'b0);
        push_exp(data_of(32'hC), 32'hC, 1'b0, 1'b0);
        wait_valid();
        drain(4);
        repeat (4) @(negedge clk);
        check("halt_req", 32'(instr_req), 32'd0);
        check("halt_valid", 32'(valid), 32'd0);
        check("halt_count", 32'(count), 32'd0);
        err_addr = 32'hFFFF_FFFF;
        redirect_to(32'h200);
        check("resume_req", 32'(instr_req), 32'd1);
        check("resume_addr", imaddr, 32'h200);
        for (int i = 0; i < 3; i++) push_exp(data_of(32'h200 + 32'(i * 4)), 32'h200 + 32'(i * 4), 1'b0, 1'b0);
        wait_valid();
        drain(3);
        repeat (8) @(negedge clk);

        // Misaligned redirect target
        redirect_to(32'h102);
        check("misal_req", 32'(instr_req), 32'd0);
        check("misal_valid_low", 32'(valid), 32'd0);
        @(negedge clk);
        check("misal_valid", 32'(valid), 32'd1);
        check("misal_pc", pc_out, 32'h102);
        check("misal_flag", 32'(misal), 32'd1);
        check("misal_instr", instr_out, 32'h0);
        check("misal_count", 32'(count), 32'd1);
        push_exp(32'h0, 32'h102, 1'b0, 1'b1);
        drain(1);
        repeat (4) @(negedge clk);
        check("misal_halt_req", 32'(instr_req), 32'd0);
        check("misal_halt_valid", 32'(valid), 32'd0);

        // Asynchronous reset with three entries queued
        redirect_to(32'h300);
        repeat (4) @(negedge clk);
        check("pre_rst_count", 32'(count), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_req", 32'(instr_req), 32'd0);
        check("arst_addr", imaddr, 32'h0);
        check("arst_pc", pc_out, 32'h0);
        check("arst_instr", instr_out, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("restart_req", 32'(instr_req), 32'd1);
        check("restart_addr", imaddr, 32'h0);
        for (int i = 0; i < 3; i++) push_exp(data_of(32'(i * 4)), 32'(i * 4), 1'b0, 1'b0);
        wait_valid();
        drain(3);
        repeat (4) @(negedge clk);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
